// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the N-requester arbiter
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam logic ARB_MODE_RR    = 1'b0;
    localparam logic ARB_MODE_FIXED = 1'b1;

    // Index following idx, wrapping at n back to zero.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_n_if.sv
// rtl/arb_n_if.sv - request/grant bundle between bus masters and the arbiter
interface arb_n_if #(
    parameter int N_REQ = 4
) (
    input logic clk
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic             mode;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             timeout;

    modport master (
        input  clk,
        output request, mode,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  clk,
        input  request, mode,
        output grant, grant_valid, grant_id, timeout
    );

endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational rotating/fixed priority picker
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [N_REQ-1:0] eligible;
    logic [ID_W-1:0]  cand;
    int               pos;

    assign eligible = req & ~mask;

    // Walk every slot once starting at ptr (or 0 in fixed mode); first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos  = (mode == ARB_MODE_FIXED) ? i : (int'(ptr) + i) % N_REQ;
            cand = ID_W'(pos);
            if (!any && eligible[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_rr_n.sv
// rtl/arb_rr_n.sv - N-requester arbiter, round-robin or fixed priority with hold limit
module arb_rr_n
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input logic    clk,
    input logic    rst,
    arb_n_if.slave bus
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              grant_valid_q;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              timeout_q, timeout_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  pick_mask;
    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              others_pending;
    logic              preempt;

    assign owner_req      = |(bus.request & grant_q);
    assign others_pending = |(bus.request & ~grant_q);
    assign preempt        = (MAX_HOLD != 0) && (state_q == ARB_BUSY) && owner_req
                            && (hold_q == HOLD_MAX) && others_pending;

    // The current owner is never a candidate while busy, so a pre-emption hands over.
    assign pick_mask = (state_q == ARB_BUSY) ? grant_q : '0;

    arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (bus.request),
        .mask   (pick_mask),
        .ptr    (ptr_q),
        .mode   (bus.mode),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_BUSY;
                    grant_d    = pick_onehot;
                    grant_id_d = pick_idx;
                    ptr_d      = ID_W'(wrap_inc(int'(pick_idx), N_REQ));
                    hold_d     = HOLD_ONE;
                end
            end
            ARB_BUSY: begin
                if (owner_req && !preempt) begin
                    if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end else if (pick_any) begin
                    grant_d    = pick_onehot;
                    grant_id_d = pick_idx;
                    ptr_d      = ID_W'(wrap_inc(int'(pick_idx), N_REQ));
                    hold_d     = HOLD_ONE;
                    timeout_d  = preempt;
                end else begin
                    state_d    = ARB_IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    hold_d     = '0;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_arb_rr_n.sv
// tb/tb_arb_rr_n.sv - bench for arb_rr_n with hold limits 2, 0 and 8
module tb_arb_rr_n;
    import arb_pkg::*;

    typedef struct {
        string      name;
        logic       rst;
        logic       mode;
        logic [3:0] req;
        int         dut;
        logic [3:0] grant;
        logic       to;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] grant;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    arb_n_if #(.N_REQ(4)) if_h2 (.clk(clk));
    arb_n_if #(.N_REQ(4)) if_h0 (.clk(clk));
    arb_n_if #(.N_REQ(4)) if_h8 (.clk(clk));

    arb_rr_n #(.N_REQ(4), .MAX_HOLD(2)) dut_h2 (.clk(clk), .rst(rst), .bus(if_h2));
    arb_rr_n #(.N_REQ(4), .MAX_HOLD(0)) dut_h0 (.clk(clk), .rst(rst), .bus(if_h0));
    arb_rr_n #(.N_REQ(4), .MAX_HOLD(8)) dut_h8 (.clk(clk), .rst(rst), .bus(if_h8));

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic add_vec(input string name, input logic r, input logic m, input logic [3:0] q,
                           input int dut, input logic [3:0] g, input logic to);
        vec_t v;
        v.name = name; v.rst = r; v.mode = m; v.req = q; v.dut = dut; v.grant = g; v.to = to;
        tbl.push_back(v);
    endtask

    task automatic step(input string name, input logic r, input logic m, input logic [3:0] q,
                        input int dut, input logic [3:0] g, input logic to);
        exp_t e;
        @(negedge clk);
        rst = r;
        if_h2.request = q; if_h2.mode = m;
        if_h0.request = q; if_h0.mode = m;
        if_h8.request = q; if_h8.mode = m;
        e.name = name; e.dut = dut; e.grant = g; e.to = to;
        sb.push_back(e);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       to;
        logic       ev;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin g = if_h2.grant; v = if_h2.grant_valid; id = if_h2.grant_id; to = if_h2.timeout; end
                1:       begin g = if_h0.grant; v = if_h0.grant_valid; id = if_h0.grant_id; to = if_h0.timeout; end
                default: begin g = if_h8.grant; v = if_h8.grant_valid; id = if_h8.grant_id; to = if_h8.timeout; end
            endcase
            ev = |e.grant;
            total++;
            if (g !== e.grant || v !== ev || to !== e.to || (ev && id !== idx_of(e.grant))) begin
                bad++;
                $display("FAIL %s: got grant=%b valid=%b id=%0d timeout=%b, want grant=%b valid=%b id=%0d timeout=%b",
                         e.name, g, v, id, to, e.grant, ev, idx_of(e.grant), e.to);
            end
        end
    end

    initial begin
        if_h2.request = '0; if_h2.mode = ARB_MODE_RR;
        if_h0.request = '0; if_h0.mode = ARB_MODE_RR;
        if_h8.request = '0; if_h8.mode = ARB_MODE_RR;

        // reset with all requesting, then round-robin rotation under a hold limit of 2
        for (int i = 0; i < 3; i++) add_vec("reset_hold", 1'b1, ARB_MODE_RR, 4'b1111, 0, 4'b0000, 1'b0);
        add_vec("first_grant", 1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0001, 1'b0);
        add_vec("rr_hold0",    1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0001, 1'b0);
        add_vec("rr_to1",      1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0010, 1'b1);
        add_vec("rr_hold1",    1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0010, 1'b0);
        add_vec("rr_to2",      1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0100, 1'b1);
        add_vec("rr_hold2",    1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0100, 1'b0);
        add_vec("rr_to3",      1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b1000, 1'b1);
        add_vec("rr_hold3",    1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b1000, 1'b0);
        add_vec("rr_wrap",     1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0001, 1'b1);
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].rst, tbl[i].mode, tbl[i].req, tbl[i].dut, tbl[i].grant, tbl[i].to);

        // fixed priority, unlimited hold, then owner hand-over with no bubble
        step("fx_reset", 1'b1, ARB_MODE_FIXED, 4'b0000, 1, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) step("fx_hold", 1'b0, ARB_MODE_FIXED, 4'b1010, 1, 4'b0010, 1'b0);
        for (int i = 0; i < 2; i++) step("fx_move", 1'b0, ARB_MODE_FIXED, 4'b1000, 1, 4'b1000, 1'b0);

        // a mode change does not take the grant from a current owner
        step("mc_reset", 1'b1, ARB_MODE_RR, 4'b0000, 1, 4'b0000, 1'b0);
        step("mc_rr",    1'b0, ARB_MODE_RR, 4'b0100, 1, 4'b0100, 1'b0);
        step("mc_keep",  1'b0, ARB_MODE_FIXED, 4'b0101, 1, 4'b0100, 1'b0);
        step("mc_fixed", 1'b0, ARB_MODE_FIXED, 4'b0001, 1, 4'b0001, 1'b0);

        // sole requester past the hold limit, then immediate pre-emption once another asks
        step("solo_reset", 1'b1, ARB_MODE_RR, 4'b0000, 2, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step("solo_hold", 1'b0, ARB_MODE_RR, 4'b0100, 2, 4'b0100, 1'b0);
        step("solo_preempt", 1'b0, ARB_MODE_RR, 4'b0110, 2, 4'b0010, 1'b1);

        // owner drops while another requests; pointer left at 3 shows in the next idle pick
        step("drop_reset", 1'b1, ARB_MODE_RR, 4'b0000, 2, 4'b0000, 1'b0);
        step("drop_own",   1'b0, ARB_MODE_RR, 4'b0001, 2, 4'b0001, 1'b0);
        step("drop_swap",  1'b0, ARB_MODE_RR, 4'b0100, 2, 4'b0100, 1'b0);
        step("drop_idle",  1'b0, ARB_MODE_RR, 4'b0000, 2, 4'b0000, 1'b0);
        step("drop_ptr3",  1'b0, ARB_MODE_RR, 4'b1011, 2, 4'b1000, 1'b0);

        // reset pulse mid-grant clears outputs and pointer
        step("mr_reset", 1'b1, ARB_MODE_RR, 4'b0000, 0, 4'b0000, 1'b0);
        step("mr_own",   1'b0, ARB_MODE_RR, 4'b0010, 0, 4'b0010, 1'b0);
        step("mr_pulse", 1'b1, ARB_MODE_RR, 4'b1111, 0, 4'b0000, 1'b0);
        step("mr_ptr0",  1'b0, ARB_MODE_RR, 4'b1111, 0, 4'b0001, 1'b0);

        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
